dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Services load/store requests issued by the MEM stage of the pipelined core.
- Returns load data combinationally on a hit, so ReadData_m settles before the MEM/WB register captures it.
- On a miss or store it stalls the pipeline and runs a simple request/response protocol to main memory (line refill, word write-through).

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32.
- NUM_SETS, 16, number of lines; power of two.
- BLOCK_WORDS, 4, words per line; power of two.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  MEM stage has a memory operation this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored for lookup.
- cpu_wdata  in  DATA_WIDTH  store data, already lane-aligned.
- cpu_byte_en  in  4  store byte lanes.
- cpu_rdata  out  DATA_WIDTH  load data (to ReadData_m).
- cpu_stall  out  1  freeze the pipeline; the request is held stable while this is high.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_byte_en  out  4  write lanes.
- mem_rdata_valid  in  1  read response strobe.
- mem_rdata  in  DATA_WIDTH  read response data.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Address split, defaults: offset [3:0] (word select [3:2]), index [7:4], tag [31:8]. Widths derive from the parameters.
- Storage: valid bit and tag per set; BLOCK_WORDS words of data per set.
- Reset:
  - All valid bits cleared; state = IDLE; word counter = 0.
  - mem_req_valid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_byte_en = 0.
  - cpu_stall = 0 when cpu_req_valid is low.
  - Reset mid-refill or mid-write abandons the transaction. Late mem_rdata_valid responses after reset are ignored.
- hit = valid[index] && tag match.
- cpu_rdata: selected word when in IDLE with cpu_req_valid && !cpu_we && hit; otherwise 0.
- cpu_stall (combinational):
  - High in IDLE when cpu_req_valid && (store || !hit).
  - High in every non-IDLE state.
  - Load hit: 0-cycle latency, no stall.
- FSM states and transitions:
  - IDLE:
    - Load miss -> RF_REQ with counter = 0.
    - Store -> WR_REQ. If the store hits, the line's data word is updated per byte_en at this clock edge. On a miss nothing is allocated.
  - RF_REQ:
    - mem_req_valid = 1, mem_we = 0, mem_addr = {tag, index, counter, 2'b00}.
    - On mem_req_ready -> RF_WAIT.
    - mem_req_valid and mem_addr stay stable until accepted.
  - RF_WAIT:
    - On mem_rdata_valid, write mem_rdata into word[counter].
    - If counter == BLOCK_WORDS-1: set valid and tag, go to IDLE (the held load then hits).
    - Otherwise counter++ and go to RF_REQ.
    - Words are fetched in ascending order, one outstanding request.
  - WR_REQ:
    - mem_req_valid = 1, mem_we = 1, mem_addr = word-aligned cpu_addr, mem_wdata = cpu_wdata, mem_byte_en = cpu_byte_en.
    - On mem_req_ready -> DONE.
  - DONE:
    - cpu_stall = 1 for this one cycle, then IDLE.
    - The held store is not re-executed: DONE consumes it, and the pipeline advances at the next edge.
    - Stall is still asserted in this cycle; the stall drops in IDLE only because the pipeline has moved on.
- Simultaneous events:
  - mem_rdata_valid outside RF_WAIT is ignored.
  - mem_req_ready while mem_req_valid = 0 is ignored.
- cpu_req_valid low in IDLE: no lookup, stall 0, no state change.
- Conflict miss: refill overwrites the set unconditionally; no writeback is needed (write-through).
- Counter wrap: counter is log2(BLOCK_WORDS) bits and is reset to 0 on entry to refill.
- Refill of the last word and return to IDLE occur at the same edge; valid is visible the next cycle.

Test Plan:
- Cold load miss:
  - Stimulus: load 0x100; memory returns 0x11, 0x22, 0x33, 0x44 for addresses 0x100, 0x104, 0x108, 0x10C, each with 2-cycle ready latency.
  - Required: stall high through four request/response pairs, then cpu_rdata = 0x11 with stall 0.
  - Follow-up: load 0x108 -> rdata = 0x33, zero stall.
- Store hit, byte lane:
  - Stimulus: after the cold miss, store 0x101, byte_en = 4'b0010, wdata = 0x0000AB00.
  - Required: one mem write (addr 0x100, byte_en 0010) with stall until accepted plus DONE.
  - Follow-up: load 0x100 -> 0x0000AB11, no memory traffic.
- Store miss: store 0x300 on an empty cache -> single memory write, no refill; then load 0x300 misses and refills.
- Conflict:
  - Stimulus: load 0x100, then load 0x200 (same index 0, different tag).
  - Required: second access refills from 0x200..0x20C.
  - Follow-up: load 0x100 misses again.
- Backpressure: hold mem_req_ready low 5 cycles during RF_REQ -> mem_req_valid and mem_addr stable, no response accepted, stall held.
- Reset mid-refill:
  - Stimulus: assert rst_n low after two refill words.
  - Required: outputs return to reset values immediately; after release, load 0x100 misses and refills from word 0.

Source files
------------

// File: rtl/dcache_responder_if.sv
// CPU-side and memory-side signal bundle for the data cache.
// slave = cache view, master = pipeline/memory environment view.
interface dcache_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req_valid;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [3:0]            cpu_byte_en;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_byte_en;
    logic                  mem_rdata_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
        input  mem_req_ready, mem_rdata_valid, mem_rdata,
        output cpu_rdata, cpu_stall,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_byte_en
    );

    modport master (
        output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
        output mem_req_ready, mem_rdata_valid, mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_byte_en
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Load hits return data combinationally; misses refill a whole line one word
// at a time, stores are written through as a single word request.
module dcache_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4
) (
    input logic clk,
    input logic rst_n,
    dcache_responder_if.slave bus
);
    localparam int WSEL_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(BLOCK_WORDS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RF_REQ  = 3'd1;
    localparam logic [2:0] S_RF_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state;
    logic [WSEL_W-1:0]     cnt;
    logic [NUM_SETS-1:0]   valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_q [NUM_SETS][BLOCK_WORDS];

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic              hit;
    logic              access;
    logic              unused_addr_lsb;

    assign tag             = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign idx             = bus.cpu_addr[OFF_W +: IDX_W];
    assign wsel            = bus.cpu_addr[2 +: WSEL_W];
    assign unused_addr_lsb = ^bus.cpu_addr[1:0];
    assign hit             = valid_q[idx] && (tag_q[idx] == tag);
    // A lookup only happens when the FSM is free to take a new request.
    assign access          = (state == S_IDLE) && bus.cpu_req_valid;

    // CPU response and memory request outputs, decoded from state.
    always_comb begin
        bus.cpu_rdata     = '0;
        bus.cpu_stall     = (state != S_IDLE) || (access && (bus.cpu_we || !hit));
        bus.mem_req_valid = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_byte_en   = '0;
        if (access && !bus.cpu_we && hit)
            bus.cpu_rdata = data_q[idx][wsel];
        case (state)
            S_RF_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = {tag, idx, cnt, 2'b00};
            end
            S_WR_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_we        = 1'b1;
                bus.mem_addr      = {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                bus.mem_wdata     = bus.cpu_wdata;
                bus.mem_byte_en   = bus.cpu_byte_en;
            end
            default: ;
        endcase
    end

    // Control FSM, refill word counter and per-set valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            valid_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && bus.cpu_we) begin
                        state <= S_WR_REQ;
                    end else if (access && !hit) begin
                        // Line is being replaced; it must not hit half-filled.
                        state        <= S_RF_REQ;
                        cnt          <= '0;
                        valid_q[idx] <= 1'b0;
                    end
                end
                S_RF_REQ:
                    if (bus.mem_req_ready) state <= S_RF_WAIT;
                S_RF_WAIT:
                    if (bus.mem_rdata_valid) begin
                        if (cnt == LAST_WORD) begin
                            valid_q[idx] <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_RF_REQ;
                        end
                    end
                S_WR_REQ:
                    if (bus.mem_req_ready) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays: refill writes and store-hit byte merges.
    always_ff @(posedge clk) begin
        if (state == S_RF_WAIT && bus.mem_rdata_valid) begin
            data_q[idx][cnt] <= bus.mem_rdata;
            if (cnt == LAST_WORD) tag_q[idx] <= tag;
        end
        if (access && bus.cpu_we && hit) begin
            for (int b = 0; b < 4; b++)
                if (bus.cpu_byte_en[b])
                    data_q[idx][wsel][8*b +: 8] <= bus.cpu_wdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a memory responder, a reference
// memory/residency model, and a per-cycle compare process.
module tb_dcache_responder;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dcache_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(16), .BLOCK_WORDS(BW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Memory contents as seen by the DUT (phys) and as the spec implies (ref_m).
    logic [31:0] phys  [logic [31:0]];
    logic [31:0] ref_m [logic [31:0]];
    // Which line each set should hold.
    bit          res_v [16];
    logic [23:0] res_t [16];

    // Responder state and traffic log.
    int          ready_lat = 2;
    int          hold = 0;
    bit          stray = 0;
    bit          late_pulse = 0;
    int          lat_cnt = 0;
    bit          hs_we;
    logic [31:0] hs_addr, hs_wdata;
    logic [3:0]  hs_be;
    logic [31:0] rd_log[$];
    int          nwr = 0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_m.exists(a) ? ref_m[a] : dflt(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: ready after ready_lat cycles of valid (plus hold),
    // read data returned the cycle after the accepting edge.
    initial begin
        bus.mem_req_ready   = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.mem_req_ready = 1'b0; bus.mem_rdata_valid = 1'b0;
                bus.mem_rdata = '0; lat_cnt = 0;
                continue;
            end
            bus.mem_rdata_valid = 1'b0;
            bus.mem_rdata = '0;
            if (late_pulse) begin
                bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0; late_pulse = 0;
            end
            if (bus.mem_req_ready) begin
                bus.mem_req_ready = 1'b0;
                if (hs_we) begin
                    phys[hs_addr] = merge(phys_rd(hs_addr), hs_wdata, hs_be);
                    nwr++; wr_addr = hs_addr; wr_data = hs_wdata; wr_be = hs_be;
                end else begin
                    rd_log.push_back(hs_addr);
                    bus.mem_rdata_valid = 1'b1;
                    bus.mem_rdata = phys_rd(hs_addr);
                end
            end else if (bus.mem_req_valid) begin
                if (hold > 0) hold--;
                else if (lat_cnt + 1 >= ready_lat) begin
                    bus.mem_req_ready = 1'b1; lat_cnt = 0;
                    hs_we = bus.mem_we; hs_addr = bus.mem_addr;
                    hs_wdata = bus.mem_wdata; hs_be = bus.mem_byte_en;
                end else lat_cnt++;
            end
            if (stray && !bus.mem_rdata_valid && bus.mem_req_valid) begin
                bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Per-cycle compare against the reference memory and handshake rules.
    initial begin
        bit          pv = 0, prdy = 0;
        logic [31:0] pa = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin pv = 0; continue; end
            if (bus.cpu_req_valid && !bus.cpu_we && !bus.cpu_stall)
                chk("cmp_rdata", bus.cpu_rdata, ref_rd({bus.cpu_addr[31:2], 2'b00}));
            else
                chk("cmp_rdata_zero", bus.cpu_rdata, 32'h0);
            if (!bus.cpu_req_valid) chk("cmp_idle_stall", {31'b0, bus.cpu_stall}, 32'h0);
            if (pv && !prdy) begin
                chk("cmp_hold_valid", {31'b0, bus.mem_req_valid}, 32'h1);
                chk("cmp_hold_addr", bus.mem_addr, pa);
            end
            pv = bus.mem_req_valid; pa = bus.mem_addr;
            #3 prdy = bus.mem_req_ready;
        end
    end

    // One CPU operation held until the cache releases it.
    task automatic op(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input bit use_lit, input logic [31:0] lit, input string nm);
        int          ix  = int'(a[7:4]);
        bit          hit = res_v[ix] && res_t[ix] == a[31:8];
        logic [31:0] base = {a[31:4], 4'b0};
        int          cyc = 0;
        int          exp_cyc = 1 + BW * (ready_lat + 1) + hold;
        rd_log.delete(); nwr = 0;
        @(negedge clk); #2;
        bus.cpu_req_valid = 1'b1; bus.cpu_we = we; bus.cpu_addr = a;
        bus.cpu_wdata = wd; bus.cpu_byte_en = be;
        if (!we) begin
            do begin @(negedge clk); #1; cyc++; end while (bus.cpu_stall && cyc < 400);
            chk({nm, "_released"}, {31'b0, bus.cpu_stall}, 32'h0);
            chk({nm, "_nreads"}, rd_log.size(), hit ? 0 : BW);
            if (!hit) for (int i = 0; i < rd_log.size() && i < BW; i++)
                chk({nm, "_raddr"}, rd_log[i], base + 32'(4 * i));
            chk({nm, "_cycles"}, cyc, hit ? 1 : exp_cyc);
            chk({nm, "_nwrites"}, nwr, 0);
            if (use_lit) chk({nm, "_lit"}, bus.cpu_rdata, lit);
            res_v[ix] = 1'b1; res_t[ix] = a[31:8];
        end else begin
            do begin @(negedge clk); #1; cyc++; end while (nwr == 0 && cyc < 400);
            chk({nm, "_nwrites"}, nwr, 1);
            chk({nm, "_done_stall"}, {31'b0, bus.cpu_stall}, 32'h1);
            chk({nm, "_cycles"}, cyc, ready_lat + 1);
            chk({nm, "_waddr"}, wr_addr, {a[31:2], 2'b00});
            chk({nm, "_wbe"}, {28'b0, wr_be}, {28'b0, be});
            chk({nm, "_wdata"}, wr_data, wd);
            chk({nm, "_nreads"}, rd_log.size(), 0);
            ref_m[{a[31:2], 2'b00}] = merge(ref_rd({a[31:2], 2'b00}), wd, be);
        end
        #1 bus.cpu_req_valid = 1'b0;
        if (we) begin
            @(negedge clk); #1;
            chk({nm, "_post_stall"}, {31'b0, bus.cpu_stall}, 32'h0);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_stall"}, {31'b0, bus.cpu_stall}, 32'h0);
        chk({nm, "_rdata"}, bus.cpu_rdata, 32'h0);
        chk({nm, "_mvalid"}, {31'b0, bus.mem_req_valid}, 32'h0);
        chk({nm, "_mwe"}, {31'b0, bus.mem_we}, 32'h0);
        chk({nm, "_maddr"}, bus.mem_addr, 32'h0);
        chk({nm, "_mwdata"}, bus.mem_wdata, 32'h0);
        chk({nm, "_mbe"}, {28'b0, bus.mem_byte_en}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n = 0;
        phys[32'h100] = 32'h11; phys[32'h104] = 32'h22; phys[32'h108] = 32'h33; phys[32'h10C] = 32'h44;
        ref_m[32'h100] = 32'h11; ref_m[32'h104] = 32'h22; ref_m[32'h108] = 32'h33; ref_m[32'h10C] = 32'h44;
        bus.cpu_req_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_byte_en = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        op(1'b1, 32'h300, 32'hCAFE_0300, 4'b1111, 1'b0, 32'h0, "store_miss");
        op(1'b0, 32'h300, 32'h0, 4'h0, 1'b1, 32'hCAFE_0300, "load_300_refill");
        op(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0000_0011, "cold_100");
        op(1'b0, 32'h108, 32'h0, 4'h0, 1'b1, 32'h0000_0033, "hit_108");
        op(1'b1, 32'h101, 32'h0000_AB00, 4'b0010, 1'b0, 32'h0, "store_hit");
        op(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0000_AB11, "hit_100_merged");
        op(1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 32'h5A00_0200, "conflict_200");
        op(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0000_AB11, "conflict_100");
        hold = 5; stray = 1;
        op(1'b0, 32'h210, 32'h0, 4'h0, 1'b1, 32'h5A00_0210, "backpressure");
        stray = 0;
        op(1'b0, 32'h104, 32'h0, 4'h0, 1'b1, 32'h0000_0022, "hit_104");

        // Reset while a refill of set 0 is half done.
        rd_log.delete();
        @(negedge clk); #2;
        bus.cpu_req_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200;
        do begin @(negedge clk); #1; n++; end while (rd_log.size() < 2 && n < 200);
        chk("midrefill_words", rd_log.size(), 2);
        #1 rst_n = 1'b0; bus.cpu_req_valid = 1'b0;
        #1 chk_reset_outputs("midrefill_reset");
        for (int i = 0; i < 16; i++) res_v[i] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1; late_pulse = 1;
        repeat (2) @(negedge clk);
        op(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0000_AB11, "after_reset_100");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
